// File: rtl/opb_event_counter_bank.sv
// OPB slave exposing a bank of per-channel event counters with coherent
// snapshot registers, sticky overflow flags and fabric/bus snapshot and clear.
module opb_event_counter_bank #(
   parameter logic [31:0] C_BASEADDR   = 32'h01188400,
   parameter logic [31:0] C_HIGHADDR   = 32'h011884FF,
   parameter int          C_OPB_AWIDTH = 32,
   parameter int          C_OPB_DWIDTH = 32,
   parameter              C_FAMILY     = "virtex6",
   parameter int          N_CHAN       = 8,
   parameter int          CNT_WIDTH    = 32,
   parameter int          SATURATE     = 1
) (
   input  logic              OPB_Clk,
   input  logic              OPB_Rst,
   input  logic [0:31]       OPB_ABus,
   input  logic [0:3]        OPB_BE,
   input  logic [0:31]       OPB_DBus,
   input  logic              OPB_RNW,
   input  logic              OPB_select,
   input  logic              OPB_seqAddr,
   output logic [0:31]       Sl_DBus,
   output logic              Sl_xferAck,
   output logic              Sl_errAck,
   output logic              Sl_retry,
   output logic              Sl_toutSup,
   input  logic [N_CHAN-1:0] user_event_in,
   input  logic              user_snap_in,
   input  logic              user_clr_in
);

   // Elaboration-time guard on the supported parameter ranges.
   if (C_OPB_AWIDTH != 32 || C_OPB_DWIDTH != 32 ||
       N_CHAN < 1 || N_CHAN > 32 || CNT_WIDTH < 1 || CNT_WIDTH > 32) begin : g_param_check
      $error("opb_event_counter_bank: unsupported parameter combination");
   end

   localparam logic [31:0] CTRL_WORD = {16'h0002, 8'(N_CHAN), 8'(CNT_WIDTH)};

   // Next counter value on an event: hold or wrap at the top of the range.
   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      if (&v) begin
         return (SATURATE != 0) ? v : '0;
      end
      return v + CNT_WIDTH'(1);
   endfunction

   logic [CNT_WIDTH-1:0] cnt_q  [N_CHAN];
   logic [CNT_WIDTH-1:0] snap_q [N_CHAN];
   logic [N_CHAN-1:0]    ovf_q;

   logic        ack_q;
   logic [31:0] rdata_q;
   logic        wr_snap_q;
   logic        wr_clr_q;

   logic        hit;
   logic        take;
   logic [5:0]  word_off;
   logic [31:0] rdata;
   logic        ctrl_wr;
   logic        snap_req;
   logic        clr_req;

   assign word_off = OPB_ABus[24:29];
   assign hit      = OPB_select && (OPB_ABus >= C_BASEADDR) && (OPB_ABus <= C_HIGHADDR);
   assign take     = hit && !ack_q;
   assign ctrl_wr  = take && !OPB_RNW && OPB_BE[3] && (word_off == 6'd0);

   // Fabric strobes and latched bus commands are merged into one request each.
   assign snap_req = user_snap_in | wr_snap_q;
   assign clr_req  = user_clr_in  | wr_clr_q;

   // Read multiplexer over CTRL, OVF and the snapshot registers.
   always_comb begin
      rdata = '0;
      if (word_off == 6'd0) begin
         rdata = CTRL_WORD;
      end else if (word_off == 6'd1) begin
         rdata = 32'(ovf_q);
      end else begin
         for (int i = 0; i < N_CHAN; i++) begin
            if (word_off == 6'(i + 2)) begin
               rdata = 32'(snap_q[i]);
            end
         end
      end
   end

   // Bus handshake: one-cycle ack after a hit, read data and write commands latched with it.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         ack_q     <= 1'b0;
         rdata_q   <= '0;
         wr_snap_q <= 1'b0;
         wr_clr_q  <= 1'b0;
      end else begin
         ack_q     <= take;
         rdata_q   <= (take && OPB_RNW) ? rdata : '0;
         wr_snap_q <= ctrl_wr && OPB_DBus[31];
         wr_clr_q  <= ctrl_wr && OPB_DBus[30];
      end
   end

   // Counters, sticky overflow and atomic snapshot of pre-increment values.
   always_ff @(posedge OPB_Clk) begin
      if (OPB_Rst) begin
         ovf_q <= '0;
         for (int i = 0; i < N_CHAN; i++) begin
            cnt_q[i]  <= '0;
            snap_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < N_CHAN; i++) begin
            if (snap_req) begin
               snap_q[i] <= cnt_q[i];
            end
            if (clr_req) begin
               cnt_q[i] <= '0;
               ovf_q[i] <= 1'b0;
            end else if (user_event_in[i]) begin
               cnt_q[i] <= sat_inc(cnt_q[i]);
               if (&cnt_q[i]) begin
                  ovf_q[i] <= 1'b1;
               end
            end
         end
      end
   end

   // Reset suppresses any ack still in flight; data is zero whenever ack is low.
   assign Sl_xferAck = ack_q && !OPB_Rst;
   assign Sl_DBus    = Sl_xferAck ? rdata_q : '0;
   assign Sl_errAck  = 1'b0;
   assign Sl_retry   = 1'b0;
   assign Sl_toutSup = 1'b0;

   logic unused_ok;
   assign unused_ok = &{1'b0, OPB_seqAddr, OPB_BE[0:2], OPB_DBus[0:29],
                        (C_FAMILY == "virtex6")};

endmodule

// File: tb/tb_opb_event_counter_bank.sv
// Directed bench: one default-configured bank plus two 4-bit banks
// (saturating and wrapping) sharing the same OPB bus and fabric strobes.
module tb_opb_event_counter_bank;

   localparam logic [31:0] BASE = 32'h01188400;

   logic        clk = 1'b0;
   logic        rst;
   logic [0:31] abus;
   logic [0:3]  be;
   logic [0:31] dbus_in;
   logic        rnw, sel, seq;
   logic [7:0]  ev_m, ev_s;
   logic        snap, clr;

   logic [0:31] dbus_m, dbus_s, dbus_w;
   logic        ack_m, ack_s, ack_w;
   logic [2:0]  tie_m, tie_s, tie_w;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   opb_event_counter_bank u_main (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(dbus_m), .Sl_xferAck(ack_m),
      .Sl_errAck(tie_m[0]), .Sl_retry(tie_m[1]), .Sl_toutSup(tie_m[2]),
      .user_event_in(ev_m), .user_snap_in(snap), .user_clr_in(clr));

   opb_event_counter_bank #(.CNT_WIDTH(4), .SATURATE(1)) u_sat (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(dbus_s), .Sl_xferAck(ack_s),
      .Sl_errAck(tie_s[0]), .Sl_retry(tie_s[1]), .Sl_toutSup(tie_s[2]),
      .user_event_in(ev_s), .user_snap_in(snap), .user_clr_in(clr));

   opb_event_counter_bank #(.CNT_WIDTH(4), .SATURATE(0)) u_wrap (
      .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus_in),
      .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
      .Sl_DBus(dbus_w), .Sl_xferAck(ack_w),
      .Sl_errAck(tie_w[0]), .Sl_retry(tie_w[1]), .Sl_toutSup(tie_w[2]),
      .user_event_in(ev_s), .user_snap_in(snap), .user_clr_in(clr));

   typedef struct {
      string       nm;
      logic [31:0] addr;
      logic [31:0] em;
      logic [31:0] es;
      logic [31:0] ew;
      logic        eack;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   task automatic rd_chk(input string nm, input logic [31:0] addr,
                         input logic [31:0] em, input logic [31:0] es,
                         input logic [31:0] ew, input logic eack);
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = addr; be = 4'hF;
      @(negedge clk);
      chk({nm, " ack"}, 32'({ack_m, ack_s, ack_w}), 32'({3{eack}}));
      chk({nm, " main"}, dbus_m, em);
      chk({nm, " sat"},  dbus_s, es);
      chk({nm, " wrap"}, dbus_w, ew);
      sel = 1'b0; abus = '0;
   endtask

   task automatic bus_wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] bes);
      @(negedge clk);
      sel = 1'b1; rnw = 1'b0; abus = addr; dbus_in = data; be = bes;
      @(negedge clk);
      chk("wr ack", 32'({ack_m, ack_s, ack_w}), 32'h7);
      sel = 1'b0; rnw = 1'b1; dbus_in = '0; be = 4'hF;
      @(negedge clk);
   endtask

   task automatic pulse(input logic [7:0] m, input logic [7:0] s, input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         ev_m = m; ev_s = s;
      end
      @(negedge clk);
      ev_m = '0; ev_s = '0;
   endtask

   task automatic fab(input logic sn, input logic cl);
      @(negedge clk);
      snap = sn; clr = cl;
      @(negedge clk);
      snap = 1'b0; clr = 1'b0;
   endtask

   task automatic add(input string nm, input logic [31:0] addr, input logic [31:0] em,
                      input logic [31:0] es, input logic [31:0] ew, input logic eack);
      vec_t v;
      v.nm = nm; v.addr = addr; v.em = em; v.es = es; v.ew = ew; v.eack = eack;
      tbl.push_back(v);
   endtask

   task automatic run_tbl();
      for (int i = 0; i < tbl.size(); i++) begin
         rd_chk(tbl[i].nm, tbl[i].addr, tbl[i].em, tbl[i].es, tbl[i].ew, tbl[i].eack);
      end
      tbl.delete();
   endtask

   initial begin
      rst = 1'b1; abus = '0; be = 4'hF; dbus_in = '0; rnw = 1'b1; sel = 1'b0; seq = 1'b0;
      ev_m = '0; ev_s = '0; snap = 1'b0; clr = 1'b0;

      // Reset state
      repeat (3) @(negedge clk);
      chk("reset ack", 32'({ack_m, ack_s, ack_w}), 32'h0);
      chk("reset dbus", dbus_m | dbus_s | dbus_w, 32'h0);
      chk("tied outputs", 32'({tie_m, tie_s, tie_w}), 32'h0);
      rst = 1'b0;

      // CTRL read with select held three cycles: single-cycle ack
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = BASE;
      @(negedge clk);
      chk("held ack1", 32'(ack_m), 32'h1);
      chk("held ctrl main", dbus_m, 32'h00020820);
      chk("held ctrl sat", dbus_s, 32'h00020804);
      @(negedge clk);
      chk("held ack2", 32'(ack_m), 32'h0);
      chk("held dbus2", dbus_m, 32'h0);
      @(negedge clk);
      sel = 1'b0;
      repeat (2) @(negedge clk);

      // Counting, overflow in both modes, bus snapshot with BE[3]
      pulse(8'h01, 8'h02, 5);
      pulse(8'h08, 8'h02, 2);
      pulse(8'h00, 8'h02, 13);
      bus_wr(BASE, 32'h1, 4'b0001);
      add("ctrl",    BASE + 32'h00, 32'h00020820, 32'h00020804, 32'h00020804, 1'b1);
      add("ovf",     BASE + 32'h04, 32'h0, 32'h2, 32'h2, 1'b1);
      add("snap0",   BASE + 32'h08, 32'd5, 32'd0, 32'd0, 1'b1);
      add("snap1",   BASE + 32'h0C, 32'd0, 32'd15, 32'd4, 1'b1);
      add("snap3",   BASE + 32'h14, 32'd2, 32'd0, 32'd0, 1'b1);
      add("snap7",   BASE + 32'h24, 32'd0, 32'd0, 32'd0, 1'b1);
      add("unused28",BASE + 32'h28, 32'd0, 32'd0, 32'd0, 1'b1);
      add("unusedFC",BASE + 32'hFC, 32'd0, 32'd0, 32'd0, 1'b1);
      add("above",   32'h01188500, 32'd0, 32'd0, 32'd0, 1'b0);
      add("below",   32'h011883FC, 32'd0, 32'd0, 32'd0, 1'b0);
      run_tbl();

      // Counting without snapshot leaves SNAP unchanged
      pulse(8'h01, 8'h00, 1);
      rd_chk("snap0 held", BASE + 32'h08, 32'd5, 32'd0, 32'd0, 1'b1);

      // Event + snapshot + clear in one cycle (main ch2 at 7)
      pulse(8'h04, 8'h00, 7);
      @(negedge clk);
      ev_m = 8'h04; ev_s = 8'h02; snap = 1'b1; clr = 1'b1;
      @(negedge clk);
      ev_m = '0; ev_s = '0; snap = 1'b0; clr = 1'b0;
      add("combo snap0", BASE + 32'h08, 32'd6, 32'd0, 32'd0, 1'b1);
      add("combo snap2", BASE + 32'h10, 32'd7, 32'd0, 32'd0, 1'b1);
      add("combo snap3", BASE + 32'h14, 32'd2, 32'd0, 32'd0, 1'b1);
      add("combo snap1", BASE + 32'h0C, 32'd0, 32'd15, 32'd4, 1'b1);
      add("combo ovf",   BASE + 32'h04, 32'd0, 32'd0, 32'd0, 1'b1);
      run_tbl();
      fab(1'b1, 1'b0);
      add("post snap0", BASE + 32'h08, 32'd0, 32'd0, 32'd0, 1'b1);
      add("post snap2", BASE + 32'h10, 32'd0, 32'd0, 32'd0, 1'b1);
      add("post snap1", BASE + 32'h0C, 32'd0, 32'd0, 32'd0, 1'b1);
      run_tbl();

      // Clear ignored without BE[3]; bus snapshot+clear with BE[3]
      pulse(8'h01, 8'h02, 3);
      bus_wr(BASE, 32'h2, 4'b1110);
      fab(1'b1, 1'b0);
      rd_chk("noclr snap0", BASE + 32'h08, 32'd3, 32'd0, 32'd0, 1'b1);
      rd_chk("noclr snap1", BASE + 32'h0C, 32'd0, 32'd3, 32'd3, 1'b1);
      pulse(8'h01, 8'h00, 2);
      bus_wr(BASE, 32'h3, 4'b0001);
      rd_chk("busclr snap0", BASE + 32'h08, 32'd5, 32'd0, 32'd0, 1'b1);
      pulse(8'h01, 8'h00, 1);
      fab(1'b1, 1'b0);
      rd_chk("after clr snap0", BASE + 32'h08, 32'd1, 32'd0, 32'd0, 1'b1);
      rd_chk("after clr snap1", BASE + 32'h0C, 32'd0, 32'd0, 32'd0, 1'b1);

      // Build state, then reset during a selected read
      pulse(8'h01, 8'h02, 2);
      pulse(8'h00, 8'h02, 14);
      fab(1'b1, 1'b0);
      rd_chk("pre-rst ovf",   BASE + 32'h04, 32'd0, 32'h2, 32'h2, 1'b1);
      rd_chk("pre-rst snap0", BASE + 32'h08, 32'd3, 32'd0, 32'd0, 1'b1);
      rd_chk("pre-rst snap1", BASE + 32'h0C, 32'd0, 32'd15, 32'd0, 1'b1);
      @(negedge clk);
      sel = 1'b1; rnw = 1'b1; abus = BASE + 32'h08; rst = 1'b1; ev_m = 8'h01; snap = 1'b1;
      @(negedge clk);
      chk("rst-sel ack", 32'({ack_m, ack_s, ack_w}), 32'h0);
      chk("rst-sel dbus", dbus_m | dbus_s | dbus_w, 32'h0);
      rst = 1'b0; sel = 1'b0; ev_m = '0; snap = 1'b0;
      fab(1'b1, 1'b0);
      add("rst ovf",   BASE + 32'h04, 32'd0, 32'd0, 32'd0, 1'b1);
      add("rst snap0", BASE + 32'h08, 32'd0, 32'd0, 32'd0, 1'b1);
      add("rst snap1", BASE + 32'h0C, 32'd0, 32'd0, 32'd0, 1'b1);
      add("rst ctrl",  BASE,          32'h00020820, 32'h00020804, 32'h00020804, 1'b1);
      run_tbl();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
